// File: rtl/ifstage_pipe_pkg.sv
// Shared constants for the two-stage instruction fetch unit.
package ifstage_pkg;
  localparam logic [1:0] PC_SEL_SEQ = 2'b00;
  localparam logic [1:0] PC_SEL_BR  = 2'b01;
  localparam logic [1:0] PC_SEL_JMP = 2'b10;
  localparam int INSTR_NOP   = 0;
  localparam int INSTR_BYTES = 4;

  function automatic logic is_redirect(input logic [1:0] sel);
    return (sel == PC_SEL_BR) || (sel == PC_SEL_JMP);
  endfunction
endpackage

// File: rtl/ifstage_pipe_if.sv
// Fetch <-> decode bundle: control in from decode, tagged instruction out.
interface ifstage_pipe_if #(parameter int DATA_W = 32);
  logic              PC_LdEn;
  logic [1:0]        PC_sel;
  logic [DATA_W-1:0] PC_Immed;
  logic [DATA_W-1:0] Jump_addr;
  logic [DATA_W-1:0] Instr;
  logic [DATA_W-1:0] PC_out;
  logic              Valid;

  modport master (output PC_LdEn, PC_sel, PC_Immed, Jump_addr,
                  input  Instr, PC_out, Valid);
  modport slave  (input  PC_LdEn, PC_sel, PC_Immed, Jump_addr,
                  output Instr, PC_out, Valid);
endinterface

// File: rtl/ifstage_pipe_imem_rom.sv
// Synchronous instruction ROM, one-cycle read latency.
module imem_rom #(
  parameter int    ADDR_W    = 10,
  parameter int    DATA_W    = 32,
  parameter string INIT_FILE = "imem.hex"
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] dout
);
  // Image named by INIT_FILE is loaded into mem by the integration/load flow.
  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) dout <= mem[addr];
endmodule

// File: rtl/ifstage_pipe.sv
// Two-stage fetch: F1 holds pc and addresses the ROM, F2 tags the returned word.
module ifstage_pipe
  import ifstage_pkg::*;
#(
  parameter int                DATA_W    = 32,
  parameter int                ADDR_W    = 10,
  parameter logic [DATA_W-1:0] RESET_PC  = '0,
  parameter string             INIT_FILE = "imem.hex"
) (
  input  logic           Clk,
  input  logic           Reset,
  ifstage_pipe_if.slave  fif
);
  logic [DATA_W-1:0] pc, f2_pc, br_tgt, jmp_tgt, rom_dout;
  logic [ADDR_W-1:0] rom_addr;
  logic              f2_valid, redirect;
  logic              unused_jmp_lo;

  assign redirect      = is_redirect(fif.PC_sel);
  assign br_tgt        = f2_pc + DATA_W'(INSTR_BYTES) + (fif.PC_Immed << 2);
  assign jmp_tgt       = {fif.Jump_addr[DATA_W-1:2], 2'b00};
  assign unused_jmp_lo = ^fif.Jump_addr[1:0];

  // On hold the ROM re-reads the word already at F2 so Instr stays stable.
  assign rom_addr = fif.PC_LdEn ? pc[ADDR_W+1:2] : f2_pc[ADDR_W+1:2];

  imem_rom #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .INIT_FILE(INIT_FILE)) u_rom (
    .clk  (Clk),
    .addr (rom_addr),
    .dout (rom_dout)
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      pc       <= RESET_PC;
      f2_pc    <= RESET_PC;
      f2_valid <= 1'b0;
    end else if (redirect) begin
      // Word fetched this cycle is wrong-path; drop it and leave one bubble.
      pc       <= (fif.PC_sel == PC_SEL_BR) ? br_tgt : jmp_tgt;
      f2_pc    <= pc;
      f2_valid <= 1'b0;
    end else if (fif.PC_LdEn) begin
      pc       <= pc + DATA_W'(INSTR_BYTES);
      f2_pc    <= pc;
      f2_valid <= 1'b1;
    end
  end

  assign fif.Instr  = f2_valid ? rom_dout : DATA_W'(INSTR_NOP);
  assign fif.PC_out = f2_pc;
  assign fif.Valid  = f2_valid;
endmodule

// File: tb/tb_ifstage_pipe.sv
// Bench for ifstage_pipe: directed pins plus randomized stream vs. a fetch-stream model.
module tb_ifstage_pipe;
  localparam int DW = 32;
  localparam int AW = 10;

  logic Clk = 0;
  logic Reset;
  ifstage_pipe_if #(.DATA_W(DW)) fif();

  ifstage_pipe #(.DATA_W(DW), .ADDR_W(AW), .RESET_PC(32'h0), .INIT_FILE("imem.hex")) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .fif   (fif)
  );

  always #5 Clk = ~Clk;

  int total = 0;
  int bad   = 0;
  logic [31:0] wmem [1024];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: the fetch stream as "next address to fetch" plus "what decode sees".
  logic [31:0] m_next, m_cur;
  logic        m_v;
  bit          m_ok = 0;

  always @(posedge Clk) begin
    if (Reset) begin
      m_next <= 32'h0;
      m_cur  <= 32'h0;
      m_v    <= 1'b0;
      m_ok   <= 1'b1;
    end else if (fif.PC_sel == 2'b01) begin
      m_next <= m_cur + 32'd4 + fif.PC_Immed * 32'd4;
      m_cur  <= m_next;
      m_v    <= 1'b0;
    end else if (fif.PC_sel == 2'b10) begin
      m_next <= fif.Jump_addr & ~32'd3;
      m_cur  <= m_next;
      m_v    <= 1'b0;
    end else if (fif.PC_LdEn) begin
      m_cur  <= m_next;
      m_next <= m_next + 32'd4;
      m_v    <= 1'b1;
    end
  end

  always @(negedge Clk) begin
    if (m_ok) begin
      chk("valid",  {31'b0, fif.Valid}, {31'b0, m_v});
      chk("pc_out", fif.PC_out, m_cur);
      chk("instr",  fif.Instr, m_v ? wmem[m_cur[AW+1:2]] : 32'h0);
    end
  end

  task automatic step(input logic rst, input logic ld, input logic [1:0] sel,
                      input logic [31:0] imm, input logic [31:0] jmp);
    Reset         = rst;
    fif.PC_LdEn   = ld;
    fif.PC_sel    = sel;
    fif.PC_Immed  = imm;
    fif.Jump_addr = jmp;
    @(negedge Clk);
    #1;
  endtask

  task automatic pin(input string nm, input logic v, input logic [31:0] pcv, input logic [31:0] ins);
    chk({nm, ".valid"}, {31'b0, fif.Valid}, {31'b0, v});
    chk({nm, ".pc"},    fif.PC_out, pcv);
    chk({nm, ".instr"}, fif.Instr, ins);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin
      wmem[i] = i * 32'h11;
      dut.u_rom.mem[i] = wmem[i];
    end

    // Reset held three cycles, then a sequential stream.
    for (int i = 0; i < 3; i++) step(1, 1, 2'b00, 0, 0);
    pin("rst", 0, 32'h0, 32'h0);
    step(0, 1, 2'b00, 0, 0); pin("seq0", 1, 32'h0, 32'h00);
    step(0, 1, 2'b00, 0, 0); pin("seq1", 1, 32'h4, 32'h11);
    step(0, 1, 2'b00, 0, 0); pin("seq2", 1, 32'h8, 32'h22);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 2'b00, 0, 0); pin("hold", 1, 32'h8, 32'h22);
    end
    step(0, 1, 2'b00, 0, 0); pin("resume", 1, 32'hC, 32'h33);

    // Branches and a wrapping jump, each leaving a single bubble.
    step(1, 1, 2'b00, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 2'b00, 0, 0);
    pin("pre_br", 1, 32'h8, 32'h22);
    step(0, 1, 2'b01, 32'd3, 0);          pin("br+3.bub", 0, 32'hC, 32'h0);
    step(0, 1, 2'b00, 0, 0);              pin("br+3", 1, 32'd24, 32'h66);
    step(0, 1, 2'b01, 32'hFFFF_FFFD, 0);  pin("br-3a.bub", 0, 32'd28, 32'h0);
    step(0, 1, 2'b00, 0, 0);              pin("br-3a", 1, 32'd16, 32'h44);
    step(0, 1, 2'b01, 32'hFFFF_FFFD, 0);  pin("br-3b.bub", 0, 32'd20, 32'h0);
    step(0, 1, 2'b00, 0, 0);              pin("br-3b", 1, 32'd8, 32'h22);
    step(0, 1, 2'b10, 0, 32'h0000_1007);  pin("jmp.bub", 0, 32'hC, 32'h0);
    step(0, 1, 2'b00, 0, 0);              pin("jmp", 1, 32'h1004, 32'h11);

    // Redirect during a stall, then reset while still stalled.
    step(0, 0, 2'b10, 0, 32'h40);         pin("stall_jmp", 0, 32'h1008, 32'h0);
    step(0, 0, 2'b00, 0, 0);              pin("stall_hold", 0, 32'h1008, 32'h0);
    step(1, 0, 2'b00, 0, 0);              pin("mid_rst", 0, 32'h0, 32'h0);
    step(0, 1, 2'b00, 0, 0);              pin("post_rst", 1, 32'h0, 32'h0);

    // Randomized stream against the model.
    for (int n = 0; n < 3000; n++) begin
      automatic int r = $urandom_range(0, 9);
      automatic logic [1:0] sel = (r < 7) ? 2'b00 : (r == 7) ? 2'b01 : (r == 8) ? 2'b10 : 2'b11;
      automatic logic [31:0] imm = $urandom_range(0, 127) - 64;
      step($urandom_range(0, 49) == 0, $urandom_range(0, 3) != 0, sel, imm, $urandom);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
